// File: rtl/bsg_test_pattern_node.sv
// Ring test-pattern node: transmits packets_p pattern packets and checks the
// same number of received packets against the expected pattern sequence.
module bsg_test_pattern_node #(
  parameter int ring_width_p    = 80,
  parameter int channel_width_p = 8,
  parameter int num_channels_p  = 8,
  parameter int packets_p       = 256
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [7:0]              err_count_o
);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic        error_q, error_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        tx_fire, rx_fire, mismatch;

  // Packet index in the top 16 bits; lane c carries (k + c) mod 2^channel_width_p.
  function automatic logic [ring_width_p-1:0] pattern(input logic [15:0] k);
    logic [ring_width_p-1:0]    p;
    logic [channel_width_p-1:0] lane;
    p = '0;
    p[ring_width_p-1 -: 16] = k;
    for (int c = 0; c < num_channels_p; c++) begin
      lane = channel_width_p'(k) + channel_width_p'(c);
      p[c*channel_width_p +: channel_width_p] = lane;
    end
    return p;
  endfunction

  assign v_o         = (state_q == SEND) & en_i;
  assign ready_o     = (state_q == DONE) | (((state_q == SEND) | (state_q == DRAIN)) & en_i);
  assign data_o      = pattern(tx_cnt_q);
  assign done_o      = (state_q == DONE);
  assign error_o     = error_q;
  assign err_count_o = err_cnt_q;

  assign tx_fire  = v_o & yumi_i;
  assign rx_fire  = v_i & ready_o;
  // Anything beyond the expected packet count is a stray and always mismatches.
  assign mismatch = (rx_cnt_q >= 16'(packets_p)) | (data_i != pattern(rx_cnt_q));

  always_comb begin
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    error_d   = error_q;
    err_cnt_d = err_cnt_q;
    state_d   = state_q;

    if (tx_fire) tx_cnt_d = tx_cnt_q + 16'd1;

    if (rx_fire) begin
      if (rx_cnt_q != 16'hFFFF) rx_cnt_d = rx_cnt_q + 16'd1;
      if (mismatch) begin
        error_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
    end

    case (state_q)
      IDLE:    if (en_i) state_d = SEND;
      SEND:    if (tx_fire && (tx_cnt_q == 16'(packets_p - 1))) state_d = DRAIN;
      DRAIN:   if (en_i && (rx_cnt_d >= 16'(packets_p))) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_bsg_test_pattern_node.sv
// Testbench for bsg_test_pattern_node: directed scenarios plus random traffic
// checked every cycle against a counter-based reference model.
module tb_bsg_test_pattern_node;

  localparam int N_A = 4;
  localparam int N_B = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT A (packets_p = 4)
  logic        rst_a, en_a, yumi_a, v_i_a, v_o_a, ready_a, done_a, error_a;
  logic [79:0] data_o_a, data_i_a, flip_mask;
  logic [7:0]  cnt_a;
  logic [1:0]  mode;        // 0: bench-driven, 1: loopback, 2: transmit only
  logic        flip;
  logic        yumi_r, v_i_r;
  logic [79:0] data_r;

  // DUT B (packets_p = 300)
  logic        rst_b, en_b, yumi_b, v_i_b, v_o_b, ready_b, done_b, error_b;
  logic [79:0] data_o_b, data_i_b;
  logic [7:0]  cnt_b;

  assign flip_mask = (flip && data_o_a[79:64] == 16'd2) ? 80'd1 : 80'd0;
  assign yumi_a    = (mode != 2'd0) ? v_o_a : yumi_r;
  assign v_i_a     = (mode == 2'd1) ? v_o_a : ((mode == 2'd2) ? 1'b0 : v_i_r);
  assign data_i_a  = (mode == 2'd1) ? (data_o_a ^ flip_mask) : data_r;

  bsg_test_pattern_node #(.ring_width_p(80), .channel_width_p(8), .num_channels_p(8),
                          .packets_p(N_A)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .en_i(en_a), .v_o(v_o_a), .data_o(data_o_a),
    .yumi_i(yumi_a), .v_i(v_i_a), .data_i(data_i_a), .ready_o(ready_a),
    .done_o(done_a), .error_o(error_a), .err_count_o(cnt_a));

  bsg_test_pattern_node #(.ring_width_p(80), .channel_width_p(8), .num_channels_p(8),
                          .packets_p(N_B)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .en_i(en_b), .v_o(v_o_b), .data_o(data_o_b),
    .yumi_i(yumi_b), .v_i(v_i_b), .data_i(data_i_b), .ready_o(ready_b),
    .done_o(done_b), .error_o(error_b), .err_count_o(cnt_b));

  function automatic logic [79:0] pat(input int k);
    logic [79:0] p;
    p = 80'(k % 65536) << 64;
    for (int c = 0; c < 8; c++) p = p | (80'((k + c) % 256) << (8 * c));
    return p;
  endfunction

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!done_a && i < budget) begin
      tick(1);
      i++;
    end
    chk(tag, {79'd0, done_a}, 80'd1);
  endtask

  // Reference model for DUT A: test progress expressed through counters only.
  bit          m_started, m_done, m_err;
  int          m_tx, m_rx, m_cnt;
  logic [79:0] sent_q[$];

  always @(negedge clk) begin
    bit in_send, in_drain, ev, er, bad;
    in_send  = m_started && !m_done && m_tx < N_A;
    in_drain = m_started && !m_done && m_tx >= N_A;
    ev = in_send && en_a;
    er = m_done || (m_started && en_a);
    chk("v_o", {79'd0, v_o_a}, {79'd0, ev});
    chk("ready_o", {79'd0, ready_a}, {79'd0, er});
    chk("done_o", {79'd0, done_a}, {79'd0, m_done});
    chk("error_o", {79'd0, error_a}, {79'd0, m_err});
    chk("err_count_o", {72'd0, cnt_a}, 80'(m_cnt));
    if (in_send || !m_started) chk("data_o", data_o_a, pat(m_tx));
    if (ev && yumi_a) sent_q.push_back(data_o_a);

    if (rst_a) begin
      m_started = 0; m_done = 0; m_err = 0; m_tx = 0; m_rx = 0; m_cnt = 0;
    end else if (!m_started) begin
      m_started = en_a;
    end else begin
      if (v_i_a && er) begin
        bad = (m_rx >= N_A) || (data_i_a !== pat(m_rx));
        if (bad) begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
        end
        if (m_rx < 65535) m_rx++;
      end
      if (ev && yumi_a) m_tx++;
      if (in_drain && en_a && m_rx >= N_A) m_done = 1;
    end
  end

  initial begin
    rst_a = 1; en_a = 0; mode = 2'd0; flip = 0; yumi_r = 0; v_i_r = 0; data_r = '0;
    rst_b = 1; en_b = 0; yumi_b = 0; v_i_b = 0; data_i_b = '0;
    tick(2);
    rst_a = 0;
    @(negedge clk);
    chk("reset_data", data_o_a, 80'h0000_0706050403020100);
    chk("reset_ready", {79'd0, ready_a}, 80'd0);

    // Four-packet loopback run
    tick(1);
    sent_q.delete();
    mode = 2'd1; en_a = 1;
    wait_done("lb_done", 20);
    @(negedge clk);
    chk("lb_count", 80'(sent_q.size()), 80'd4);
    if (sent_q.size() == 4) begin
      chk("lb_first", sent_q[0], 80'h0000_0706050403020100);
      chk("lb_last", sent_q[3], 80'h0003_0A09080706050403);
    end
    chk("lb_error", {79'd0, error_a}, 80'd0);
    chk("lb_errcnt", {72'd0, cnt_a}, 80'd0);

    // Consumer stalls for five cycles in SEND
    tick(1);
    rst_a = 1; mode = 2'd0; yumi_r = 0; v_i_r = 0;
    tick(1);
    rst_a = 0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_v", {79'd0, v_o_a}, 80'd1);
      chk("stall_data", data_o_a, pat(0));
      tick(1);
    end

    // Enable drops after two sends, then resumes
    mode = 2'd1;
    tick(2);
    en_a = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("pause_v", {79'd0, v_o_a}, 80'd0);
      chk("pause_ready", {79'd0, ready_a}, 80'd0);
      tick(1);
    end
    en_a = 1;
    @(negedge clk);
    chk("resume_data", data_o_a, pat(2));
    chk("resume_v", {79'd0, v_o_a}, 80'd1);
    tick(1);
    wait_done("resume_done", 20);

    // Packet 2 corrupted in loopback
    rst_a = 1; flip = 1;
    tick(1);
    rst_a = 0;
    wait_done("flip_done", 20);
    @(negedge clk);
    chk("flip_error", {79'd0, error_a}, 80'd1);
    chk("flip_errcnt", {72'd0, cnt_a}, 80'd1);

    // Reset while draining, then a clean rerun
    tick(1);
    rst_a = 1; flip = 0; mode = 2'd2;
    tick(1);
    rst_a = 0;
    tick(8);
    @(negedge clk);
    chk("drain_done", {79'd0, done_a}, 80'd0);
    chk("drain_ready", {79'd0, ready_a}, 80'd1);
    tick(1);
    rst_a = 1;
    tick(1);
    @(negedge clk);
    chk("rst_v", {79'd0, v_o_a}, 80'd0);
    chk("rst_ready", {79'd0, ready_a}, 80'd0);
    chk("rst_done", {79'd0, done_a}, 80'd0);
    chk("rst_data", data_o_a, pat(0));
    tick(1);
    rst_a = 0; mode = 2'd1;
    wait_done("rerun_done", 20);
    chk("rerun_error", {79'd0, error_a}, 80'd0);

    // Randomized traffic against the model
    mode = 2'd0;
    for (int i = 0; i < 600; i++) begin
      rst_a  = ($urandom_range(0, 59) == 0);
      en_a   = ($urandom_range(0, 9) != 0);
      yumi_r = $urandom_range(0, 1);
      v_i_r  = $urandom_range(0, 1);
      data_r = ($urandom_range(0, 3) != 0) ? pat(m_rx) : 80'({$urandom(), $urandom(), $urandom()});
      tick(1);
    end
    rst_a = 0;

    // DUT B: 300 corrupted packets saturate the error count
    rst_b = 0; en_b = 1;
    tick(1);
    v_i_b = 1; data_i_b = 80'hDEAD;
    tick(100);
    @(negedge clk);
    chk("sat_mid", {72'd0, cnt_b}, 80'd100);
    tick(1);
    tick(199);
    v_i_b = 0;
    @(negedge clk);
    chk("sat_errcnt", {72'd0, cnt_b}, 80'd255);
    chk("sat_error", {79'd0, error_b}, 80'd1);
    chk("sat_done", {79'd0, done_b}, 80'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_test_pattern_node.md
BSG_TEST_PATTERN_NODE -- requirements
Module: bsg_test_pattern_node

Interface
REQ-001 SHALL have parameter ring_width_p, default 80, ring packet width in bits.
REQ-002 SHALL have parameter channel_width_p, default 8, pattern lane width in bits.
REQ-003 SHALL have parameter num_channels_p, default 8, number of pattern lanes; channel_width_p*num_channels_p+16 SHALL equal ring_width_p.
REQ-004 SHALL have parameter packets_p, default 256, number of packets per test, in the range 1..65535.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port en_i, input, 1, node enable from the FSB.
REQ-008 SHALL have port v_o, input direction reversed: output, 1, transmit packet valid.
REQ-009 SHALL have port data_o, output, ring_width_p, transmit packet.
REQ-010 SHALL have port yumi_i, input, 1, consumer accepts data_o this cycle.
REQ-011 SHALL have port v_i, input, 1, received packet valid.
REQ-012 SHALL have port data_i, input, ring_width_p, received packet.
REQ-013 SHALL have port ready_o, output, 1, node can accept data_i.
REQ-014 SHALL have port done_o, output, 1, test complete.
REQ-015 SHALL have port error_o, output, 1, sticky mismatch flag.
REQ-016 SHALL have port err_count_o, output, 8, saturating mismatch count.

Function
REQ-017 SHALL define pattern P(k) for 16-bit index k as follows: bits [ring_width_p-1:ring_width_p-16] = k; lane c (bits [c*channel_width_p +: channel_width_p]) = (k + c) mod 2^channel_width_p.
REQ-018 SHALL implement states IDLE, SEND, DRAIN, DONE; the reset state SHALL be IDLE.
REQ-019 SHALL transition IDLE->SEND in the cycle after en_i=1 is sampled.
REQ-020 SHALL, in SEND, drive v_o = en_i and data_o = P(tx_cnt); data_o SHALL stay stable while v_o=1 and no yumi_i is received.
REQ-021 SHALL, on v_o & yumi_i, increment tx_cnt; when tx_cnt reaches packets_p-1 and is accepted, SEND->DRAIN.
REQ-022 SHALL ignore yumi_i while v_o=0; no counter changes.
REQ-023 SHALL drive ready_o = en_i in SEND and DRAIN, 1 in DONE (to absorb stray packets), and 0 in IDLE.
REQ-024 SHALL, on v_i & ready_o, compare data_i with P(rx_cnt) and increment rx_cnt; if rx_cnt >= packets_p, the packet is counted as a mismatch.
REQ-025 SHALL, on mismatch, set error_o (sticky) and increment err_count_o, saturating at 255.
REQ-026 SHALL transition DRAIN->DONE when rx_cnt equals packets_p, including the cycle in which the last receive occurs.
REQ-027 SHALL handle transmit and receive independently, so that the same cycle can accept both; a receive may occur in SEND (loopback latency 0).
REQ-028 SHALL drive done_o=1 only in DONE; DONE SHALL be held until reset.
REQ-029 SHALL keep tx_cnt and rx_cnt at 16 bits; they SHALL never wrap within a test.
REQ-030 SHALL, if en_i drops mid-test, freeze state and counters; activity SHALL resume when en_i returns.

Reset
REQ-031 SHALL, on reset_i=1, on the next edge set state=IDLE, tx_cnt=0, rx_cnt=0, v_o=0, ready_o=0, done_o=0, error_o=0, err_count_o=0, regardless of state, including mid-operation.
REQ-032 SHALL set data_o = P(0) in reset.

Verification
REQ-033 SHALL cover this scenario: packets_p=4 with loopback data_o->data_i, yumi_i=v_i=v_o, and ready_o honored -> 4 packets are sent, 0x0000_0706050403020100 first and 0x0003_0A09080706050403 last, then done_o=1, error_o=0, err_count_o=0.
REQ-034 SHALL cover this scenario: yumi_i held 0 for 5 cycles in SEND -> v_o=1 and data_o=P(0) are stable, and tx_cnt=0.
REQ-035 SHALL cover this scenario: loopback with bit 0 of packet 2 flipped -> error_o=1 and err_count_o=1, and done_o=1 after 4 receives.
REQ-036 SHALL cover this scenario: 300 corrupted packets injected with packets_p=300 -> err_count_o saturates at 255, and error_o=1.
REQ-037 SHALL cover this scenario: en_i deasserted after 2 sends for 10 cycles -> v_o=0 and ready_o=0; on resume, the next packet is P(2).
REQ-038 SHALL cover this scenario: reset_i pulsed in DRAIN -> all outputs reach their reset values next cycle; a full rerun then passes.
